// File: rtl/store_responder_pkg.sv
// Shared store-channel types and helpers: access width, responder state,
// byte-strobe and misalignment functions for the store path.
package store_responder_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } store_width_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RESPOND = 2'd2
    } store_resp_state_t;

    function automatic logic [3:0] store_strobe(
        input store_width_t width,
        input logic [1:0]   offset
    );
        logic [3:0] strobe;
        unique case (width)
            BYTE:      strobe = 4'b0001 << offset;
            HALF_WORD: strobe = offset[1] ? 4'b1100 : 4'b0011;
            WORD:      strobe = 4'b1111;
            default:   strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

    function automatic logic store_misaligned(
        input store_width_t width,
        input logic [1:0]   offset
    );
        logic bad;
        unique case (width)
            HALF_WORD: bad = offset[0];
            WORD:      bad = |offset;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_interface.sv
// Store channel between the cache store controller (master) and the
// memory-side responder (slave): one-cycle request, one-cycle done.
interface store_interface;
    import store_responder_pkg::*;

    logic         request;
    logic [31:0]  address;
    store_width_t width;
    logic [31:0]  data;
    logic         done;

    modport master (
        output request,
        output address,
        output width,
        output data,
        input  done
    );

    modport slave (
        input  request,
        input  address,
        input  width,
        input  data,
        output done
    );

endinterface

// File: rtl/store_watchdog.sv
// Saturating cycle counter. Ports: clk_i, rst_i (sync, active-high),
// clear, enable, expired. LIMIT = 0 disables expiry.
module store_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != MAX)) begin
            count_q <= count_q + CW'(1);
        end
    end

    // count_q holds the enabled cycles already elapsed, so the LIMIT-th
    // enabled cycle is the one that sees count_q == LIMIT-1.
    assign expired = (LIMIT != 0) && enable && (count_q >= LAST);

endmodule

// File: rtl/store_responder.sv
// Memory-side store responder: latches one store, checks alignment and
// issues a single word-aligned, byte-strobed write, then pulses done.
// Ports: clk_i, rst_i (sync, active-high), store_channel (slave),
// mem_write_o/address/data/strobe, mem_ready_i, error_o (qualifies done).
module store_responder
    import store_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    store_interface.slave store_channel,
    output logic         mem_write_o,
    output logic [31:0]  mem_address_o,
    output logic [31:0]  mem_data_o,
    output logic [3:0]   mem_strobe_o,
    input  logic         mem_ready_i,
    output logic         error_o
);

    store_resp_state_t state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        write_q, write_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        req_misaligned;
    logic [3:0]  req_strobe;
    logic        wd_expired;

    store_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state_q != WRITE),
        .enable  (state_q == WRITE),
        .expired (wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            write_q  <= write_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        req_misaligned = store_misaligned(store_channel.width,
                                          store_channel.address[1:0]);
        req_strobe     = store_strobe(store_channel.width,
                                      store_channel.address[1:0]);
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        write_d  = write_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (store_channel.request) begin
                    addr_d = {store_channel.address[31:2], 2'b00};
                    if (req_misaligned) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        data_d   = store_channel.data;
                        strobe_d = req_strobe;
                        write_d  = 1'b1;
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                // Ready takes priority over an expiry in the same cycle.
                if (mem_ready_i || wd_expired) begin
                    data_d   = '0;
                    strobe_d = '0;
                    write_d  = 1'b0;
                    done_d   = 1'b1;
                    error_d  = !mem_ready_i;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                data_d   = '0;
                strobe_d = '0;
                write_d  = 1'b0;
            end
        endcase
    end

    assign store_channel.done = done_q;
    assign error_o            = error_q;
    assign mem_write_o        = write_q;
    assign mem_address_o      = addr_q;
    assign mem_data_o         = data_q;
    assign mem_strobe_o       = strobe_q;

endmodule

// File: tb/tb_store_responder.sv
// Scoreboard bench for store_responder: expected writes and responses are
// queued at request time and checked when the DUT produces them.
module tb_store_responder;
    import store_responder_pkg::*;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_strobe_o;
    logic        mem_ready_i = 1'b0;
    logic        error_o;

    store_interface sif ();

    store_responder #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .store_channel (sif),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .mem_strobe_o  (mem_strobe_o),
        .mem_ready_i   (mem_ready_i),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  stb;
        int          delay;
    } wr_t;

    typedef struct {
        bit err;
        int cyc;
        int wcyc;
        bit tmo;
    } rsp_t;

    wr_t  wq[$];
    rsp_t rq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wr_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory model + output monitor, all on the falling edge.
    always @(negedge clk_i) begin
        if (cyc > 0) begin
            if (mem_write_o) begin
                if (wq.size() == 0) begin
                    mem_ready_i = 1'b0;
                    chk("wr_unexpected", 32'(mem_write_o), 32'd0);
                end else begin
                    chk("addr", mem_address_o, wq[0].addr);
                    chk("data", mem_data_o, wq[0].data);
                    chk("strobe", 32'(mem_strobe_o), 32'(wq[0].stb));
                    mem_ready_i = (wq[0].delay >= 0) &&
                                  (wr_run == wq[0].delay);
                    wr_run++;
                    if (mem_ready_i) void'(wq.pop_front());
                end
            end else begin
                mem_ready_i = 1'b0;
                chk("idle_data", mem_data_o, 32'd0);
                chk("idle_strobe", 32'(mem_strobe_o), 32'd0);
            end
            if (sif.done) begin
                if (rq.size() == 0) begin
                    chk("done_unexpected", 32'(sif.done), 32'd0);
                end else begin
                    chk("done_cycle", cyc, rq[0].cyc);
                    chk("error", 32'(error_o), 32'(rq[0].err));
                    chk("write_cycles", wr_run, rq[0].wcyc);
                    if (rq[0].tmo && wq.size() != 0) void'(wq.pop_front());
                    void'(rq.pop_front());
                end
                wr_run = 0;
            end else begin
                chk("error_idle", 32'(error_o), 32'd0);
                if (!mem_write_o) wr_run = 0;
            end
        end
    end

    // delay k: ready in the (k+1)-th write cycle; negative = never.
    task automatic issue(input logic [31:0] a, input store_width_t w,
                         input logic [31:0] d, input logic [3:0] stb,
                         input bit mis, input int k);
        int p;
        rsp_t r;
        wr_t  x;
        @(negedge clk_i);
        sif.request = 1'b1;
        sif.address = a;
        sif.width   = w;
        sif.data    = d;
        p = cyc + 1;
        if (mis) begin
            r = '{err: 1'b1, cyc: p, wcyc: 0, tmo: 1'b0};
        end else begin
            x = '{addr: {a[31:2], 2'b00}, data: d, stb: stb, delay: k};
            wq.push_back(x);
            if (k < 0 || k >= TMO)
                r = '{err: 1'b1, cyc: p + TMO, wcyc: TMO, tmo: 1'b1};
            else
                r = '{err: 1'b0, cyc: p + 1 + k, wcyc: k + 1, tmo: 1'b0};
        end
        rq.push_back(r);
        @(negedge clk_i);
        sif.request = 1'b0;
        sif.address = 32'hFFFF_FFFF;
        sif.data    = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        #1;
        while (rq.size() != 0 && n < 64) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (rq.size() != 0) begin
            chk("wait_bound", 32'(rq.size()), 32'd0);
            rq.delete();
            wq.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write"}, 32'(mem_write_o), 32'd0);
        chk({tag, "_addr"}, mem_address_o, 32'd0);
        chk({tag, "_data"}, mem_data_o, 32'd0);
        chk({tag, "_strobe"}, 32'(mem_strobe_o), 32'd0);
        chk({tag, "_done"}, 32'(sif.done), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    initial begin
        sif.request = 1'b0;
        sif.address = '0;
        sif.width   = BYTE;
        sif.data    = '0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_i = 1'b0;

        issue(32'h0000_1003, BYTE, 32'hAB00_0000, 4'b1000, 1'b0, 0);
        wait_done();
        issue(32'h0000_2000, WORD, 32'hDEAD_BEEF, 4'b1111, 1'b0, 3);
        wait_done();
        issue(32'h0000_2001, HALF_WORD, 32'h0000_BEEF, 4'b0000, 1'b1, 0);
        wait_done();
        issue(32'h0000_2002, HALF_WORD, 32'hBEEF_0000, 4'b1100, 1'b0, 1);
        wait_done();
        issue(32'h0000_4000, HALF_WORD, 32'h0000_CAFE, 4'b0011, 1'b0, 2);
        wait_done();
        issue(32'h0000_4002, WORD, 32'h1234_5678, 4'b0000, 1'b1, 0);
        wait_done();
        issue(32'h0000_4003, HALF_WORD, 32'h5500_0000, 4'b0000, 1'b1, 0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            logic [3:0]  s;
            logic [31:0] dd;
            s  = 4'b0001 << i;
            dd = 32'h0000_00C3 << (8 * i);
            issue(32'h0000_4100 + 32'(i), BYTE, dd, s, 1'b0, 0);
            wait_done();
        end

        // Never ready: abandoned after TMO write cycles.
        issue(32'h0000_5000, WORD, 32'hA5A5_0F0F, 4'b1111, 1'b0, -1);
        wait_done();
        // Ready in the last allowed cycle wins over the expiry.
        issue(32'h0000_5004, WORD, 32'h0F0F_A5A5, 4'b1111, 1'b0, TMO - 1);
        wait_done();

        // Stray request while writing must be ignored.
        issue(32'h0000_6000, WORD, 32'h600D_F00D, 4'b1111, 1'b0, 4);
        sif.request = 1'b1;
        sif.address = 32'h0000_3000;
        sif.width   = BYTE;
        sif.data    = 32'h1111_1111;
        @(negedge clk_i);
        sif.request = 1'b0;
        wait_done();
        repeat (4) @(negedge clk_i);

        // Reset during a stalled write.
        issue(32'h0000_7000, WORD, 32'h7777_0000, 4'b1111, 1'b0, -1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk_all_zero("midreset");
        wq.delete();
        rq.delete();
        rst_i = 1'b0;
        repeat (TMO + 4) @(negedge clk_i);
        #1;
        issue(32'h0000_7004, WORD, 32'h0BAD_CAFE, 4'b1111, 1'b0, 0);
        wait_done();
        repeat (3) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/store_responder.md
# store_responder

Memory-side responder of the store channel: the slave end of `store_interface` that the data cache store controller drives. It latches a single store request (address, width, lane-aligned data), checks alignment, and issues one word-aligned, byte-strobed write to the external memory write port. It returns a one-cycle `done` pulse, with an error flag for misaligned stores or a memory timeout. It sits between the cache store path and the bus/memory fabric.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum write-phase cycles without `mem_ready_i` before the write is aborted. 0 disables the timeout.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `store_channel`  slave modport  `store_interface`  fields:
  - `request`: input, 1-cycle pulse.
  - `address`: input, 32 bits.
  - `width`: input, `store_width_t`.
  - `data`: input, 32 bits, already shifted into its byte lane.
  - `done`: output.
- `mem_write_o`  out  1  write request to memory; held until accepted.
- `mem_address_o`  out  32  word-aligned address, `{address[31:2], 2'b00}`.
- `mem_data_o`  out  32  write data, passed through unshifted.
- `mem_strobe_o`  out  4  byte enables.
- `mem_ready_i`  in  1  memory accepts the write in the cycle it is high while `mem_write_o` is high.
- `error_o`  out  1  qualifies `done`: high for misaligned store or timeout.

## Operation
- FSM states: IDLE, WRITE, RESPOND.
- IDLE:
  - When `request` is high, latch address, width and data. The initiator holds data valid only in the request cycle, so latching is mandatory.
  - Aligned store: go to WRITE.
  - Misaligned store: set the error flag and go to RESPOND. No memory access is made.
- Misalignment rules:
  - HALF_WORD with `address[0]=1` is misaligned.
  - WORD with `address[1:0]≠0` is misaligned.
  - BYTE is never misaligned.
- Strobe generation:
  - BYTE: `4'b0001 << address[1:0]`.
  - HALF_WORD: `address[1] ? 4'b1100 : 4'b0011`.
  - WORD: `4'b1111`.
- WRITE:
  - `mem_write_o`=1 with registered address, data and strobe; the watchdog counts up.
  - `mem_ready_i` high: clear the error flag and go to RESPOND.
  - Counter reaches `TIMEOUT_CYCLES` with no ready: set the error flag and go to RESPOND. The write is abandoned.
  - Ready and timeout in the same cycle: ready wins, no error.
- RESPOND: `done`=1 and `error_o` = flag for exactly one cycle, then return to IDLE.
- `request` outside IDLE is a protocol violation. It is ignored and never queued; the latched transaction is unaffected.
- `mem_data_o` and `mem_strobe_o` are zero whenever `mem_write_o`=0.

## Timing
- All outputs are registered.
- Reset values: `done`=0, `error_o`=0, `mem_write_o`=0, `mem_address_o`=0, `mem_data_o`=0, `mem_strobe_o`=0. FSM goes to IDLE and the counter to 0.
- Request sampled at edge T:
  - `mem_write_o` rises at T+1.
  - If ready at cycle T+1+k, `mem_write_o` falls and `done` is high in cycle T+2+k.
  - Minimum store latency, request to `done`: 2 cycles.
- Misaligned request at T: `done`=`error_o`=1 in cycle T+1; `mem_write_o` never rises.
- Timeout: `mem_write_o` is high for exactly `TIMEOUT_CYCLES` cycles (T+1 .. T+`TIMEOUT_CYCLES`). `done`+`error_o` follow in cycle T+1+`TIMEOUT_CYCLES`.
- Back-to-back: the earliest next request is accepted in the cycle after `done` (IDLE). Throughput is 1 store per 3 cycles at zero wait.
- `rst_i` mid-operation: the transaction is dropped at the next edge, no `done` is emitted, and `mem_write_o` falls immediately. Memory must tolerate the withdrawn request.
- The watchdog counter is sized `$clog2(TIMEOUT_CYCLES+1)` and saturates. It is cleared on every entry to WRITE.

## Structure
- `store_width_t` (BYTE, HALF_WORD, WORD) is reused from the store unit package.
- Add to the cache package:
  - the responder state enum `store_resp_state_t`;
  - a function `store_strobe(width, offset)` returning the 4-bit enable;
  - a function `store_misaligned(width, offset)`.
  The store controller can later share both functions.
- One natural sub-module, `store_watchdog`: a parameterised saturating cycle counter with `clear`/`enable`/`expired`. It is reusable for a future load responder.

## Test plan
- BYTE store, address 0x0000_1003, data 0xAB00_0000, ready immediate.
  - Expect `mem_address_o`=0x0000_1000, strobe 4'b1000, data 0xAB00_0000 at T+1.
  - Expect `done`=1 and `error_o`=0 at T+2.
- WORD store, address 0x0000_2000, data 0xDEAD_BEEF, ready withheld 3 cycles.
  - Expect `mem_write_o` high T+1..T+4 with stable outputs, `done` at T+5.
- HALF_WORD store at 0x0000_2001.
  - Expect `done`=`error_o`=1 at T+1 and `mem_write_o` never asserted.
  - HALF_WORD store at 0x0000_2002: expect strobe 4'b1100.
- `TIMEOUT_CYCLES`=16, ready never asserted.
  - Expect `mem_write_o` high exactly 16 cycles, `done`+`error_o` at T+17.
  - Ready in cycle T+16: expect `done` with `error_o`=0.
- Second `request` pulse while in WRITE: expect it ignored, one `done` total, latched address and data unchanged.
- `rst_i` asserted at T+2 during a stalled write: expect all outputs 0 from T+3, no `done`, and the next request handled normally.
